// File: rtl/proc_pkg.sv
// Shared definitions for the 9-bit processor control unit, datapath and bench.
// Contents:
//   DATA_W, NREG, REG_W  - instruction width, register count, register-field width
//   tstep_e              - instruction step encoding T0..T3
//   OP_*                 - opcode values of the IR[8:6] field
//   OP_/RX_/RY_ HI/LO    - bit positions of the IR fields (IIIXXXYYY)
//   is_alu_op            - opcode needs the three-step A/G sequence
package proc_pkg;

    localparam int DATA_W = 9;
    localparam int NREG   = 8;
    localparam int REG_W  = $clog2(NREG);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_e;

    localparam logic [2:0] OP_MV  = 3'd0;
    localparam logic [2:0] OP_MVI = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;

    localparam int OP_HI = 8;
    localparam int OP_LO = 6;
    localparam int RX_HI = 5;
    localparam int RX_LO = 3;
    localparam int RY_HI = 2;
    localparam int RY_LO = 0;

    // add and sub are the only opcodes that continue past T1
    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/proc_control_unit_if.sv
// Control bundle between the control unit and the datapath.
// master (control unit): samples run/din, drives all strobes plus ir/tstep debug.
// slave  (datapath / bench): drives run/din, samples the strobes.
interface proc_control_unit_if;
    import proc_pkg::*;

    logic              run;
    logic [DATA_W-1:0] din;
    logic [NREG-1:0]   rin;
    logic [NREG-1:0]   rout;
    logic              ain;
    logic              gin;
    logic              gout;
    logic              dinout;
    logic              addsub;
    logic              done;
    logic [DATA_W-1:0] ir;
    logic [1:0]        tstep;

    modport master (
        input  run, din,
        output rin, rout, ain, gin, gout, dinout, addsub, done, ir, tstep
    );

    modport slave (
        output run, din,
        input  rin, rout, ain, gin, gout, dinout, addsub, done, ir, tstep
    );

endinterface

// File: rtl/proc_control_unit_dec3to8.sv
// 3-bit to one-hot 8-bit decoder with enable.
// Ports: en (enable), sel (binary index), onehot (bit sel set when en, else all zero).
module dec3to8 (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [7:0] onehot
);

    // one-hot decode gated by enable
    always_comb begin
        onehot = 8'h00;
        if (en) begin
            onehot[sel] = 1'b1;
        end else begin
            onehot = 8'h00;
        end
    end

endmodule

// File: rtl/proc_control_unit.sv
// Control FSM of the 9-bit processor. Latches the instruction from din on run in T0,
// then sequences the datapath strobes over T1..T3 and pulses done on the last step.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - proc_control_unit_if.master: run/din in; rin, rout, ain, gin, gout, dinout,
//          addsub, done strobes out (combinational from tstep and ir); ir/tstep debug out
module proc_control_unit
    import proc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    proc_control_unit_if.master  bus
);

    tstep_e            tstep_r;
    logic [DATA_W-1:0] ir_r;

    logic [2:0]        op_s;
    logic [REG_W-1:0]  rx_s;
    logic [REG_W-1:0]  ry_s;

    logic              rin_en_s;
    logic              rout_en_s;
    logic [REG_W-1:0]  rout_sel_s;
    logic              ain_s;
    logic              gin_s;
    logic              gout_s;
    logic              dinout_s;
    logic              addsub_s;
    logic              done_s;
    logic [NREG-1:0]   rin_s;
    logic [NREG-1:0]   rout_s;

    // all fields come from the latched IR, never from the live din
    assign op_s = ir_r[OP_HI:OP_LO];
    assign rx_s = ir_r[RX_HI:RX_LO];
    assign ry_s = ir_r[RY_HI:RY_LO];

    // step sequencer and instruction latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tstep_r <= T0;
            ir_r    <= {DATA_W{1'b0}};
        end else begin
            case (tstep_r)
                T0: begin
                    if (bus.run) begin
                        ir_r    <= bus.din;
                        tstep_r <= T1;
                    end else begin
                        tstep_r <= T0;
                    end
                end
                T1: begin
                    if (is_alu_op(op_s)) begin
                        tstep_r <= T2;
                    end else begin
                        tstep_r <= T0;
                    end
                end
                T2:      tstep_r <= T3;
                T3:      tstep_r <= T0;
                default: tstep_r <= T0;
            endcase
        end
    end

    // strobe decode; rst forces every strobe low even before the flops settle
    always_comb begin
        rin_en_s   = 1'b0;
        rout_en_s  = 1'b0;
        rout_sel_s = ry_s;
        ain_s      = 1'b0;
        gin_s      = 1'b0;
        gout_s     = 1'b0;
        dinout_s   = 1'b0;
        addsub_s   = 1'b0;
        done_s     = 1'b0;
        if (rst) begin
            done_s = 1'b0;
        end else begin
            case (tstep_r)
                T1: begin
                    case (op_s)
                        OP_MV: begin
                            rout_en_s  = 1'b1;
                            rout_sel_s = ry_s;
                            rin_en_s   = 1'b1;
                            done_s     = 1'b1;
                        end
                        OP_MVI: begin
                            dinout_s = 1'b1;
                            rin_en_s = 1'b1;
                            done_s   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            // first operand Rx goes to A
                            rout_en_s  = 1'b1;
                            rout_sel_s = rx_s;
                            ain_s      = 1'b1;
                        end
                        default: begin
                            // reserved opcodes complete as a NOP
                            done_s = 1'b1;
                        end
                    endcase
                end
                T2: begin
                    if (is_alu_op(op_s)) begin
                        rout_en_s  = 1'b1;
                        rout_sel_s = ry_s;
                        gin_s      = 1'b1;
                        addsub_s   = (op_s == OP_SUB);
                    end else begin
                        rout_en_s = 1'b0;
                    end
                end
                T3: begin
                    if (is_alu_op(op_s)) begin
                        gout_s   = 1'b1;
                        rin_en_s = 1'b1;
                        done_s   = 1'b1;
                    end else begin
                        gout_s = 1'b0;
                    end
                end
                default: begin
                    done_s = 1'b0;
                end
            endcase
        end
    end

    dec3to8 u_rin_dec (
        .en     (rin_en_s),
        .sel    (rx_s),
        .onehot (rin_s)
    );

    dec3to8 u_rout_dec (
        .en     (rout_en_s),
        .sel    (rout_sel_s),
        .onehot (rout_s)
    );

    assign bus.rin    = rin_s;
    assign bus.rout   = rout_s;
    assign bus.ain    = ain_s;
    assign bus.gin    = gin_s;
    assign bus.gout   = gout_s;
    assign bus.dinout = dinout_s;
    assign bus.addsub = addsub_s;
    assign bus.done   = done_s;
    assign bus.ir     = ir_r;
    assign bus.tstep  = tstep_r;

endmodule
